// File: rtl/ledstring_rx.sv
// ledstring_rx: receives an APA102-style LED string (sck/mosi, MSB first),
// finds the 32-zero start frame, decodes pixel words and reports frame
// start/end/error events as single-cycle strobes in the CLK domain.
// Strobes carry no backpressure: pixel_valid, frame_start, frame_end and
// frame_error each assert for exactly one CLK cycle. The data outputs hold
// their values until the next pixel_valid.
// dbg_state mirrors the FSM: 0 = HUNT, 1 = PIXEL, 2 = END_WAIT.
`timescale 1ns/1ps
module ledstring_rx #(
    parameter int STRING_SIZE  = 46,
    parameter int IDLE_TIMEOUT = 4096
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       sck,
    input  logic       mosi,
    output logic       pixel_valid,
    output logic [7:0] pixel_index,
    output logic [4:0] brightness,
    output logic [7:0] blue_out,
    output logic [7:0] green_out,
    output logic [7:0] red_out,
    output logic       frame_start,
    output logic       frame_end,
    output logic       frame_error,
    output logic [7:0] pixel_count,
    output logic [1:0] dbg_state
);
    localparam int            IW        = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [7:0]    LAST_IDX  = 8'(STRING_SIZE - 1);

    typedef enum logic [1:0] {
        ST_HUNT     = 2'd0,
        ST_PIXEL    = 2'd1,
        ST_END_WAIT = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_sck_s1, r_sck_s2, r_sck_prev;
    logic          r_mosi_s1, r_mosi_s2;
    // Older 31 bits of the shift register; the newest bit is the synced
    // mosi itself, so the full 32-bit word is {r_shift, r_mosi_s2}.
    logic [30:0]   r_shift;
    logic [4:0]    r_bit_cnt;
    // Consecutive zero bits seen, saturating at 32. Starting from 0 after
    // reset means a start frame needs 32 real zeros on the wire.
    logic [5:0]    r_zero_run;
    logic [IW-1:0] r_idle;
    logic [7:0]    r_index;

    logic          w_rise;
    logic [31:0]   w_word;
    logic          w_word_done;
    logic          w_idle_hit;
    logic          w_start_hunt;
    logic          w_pix, w_start, w_end, w_err, w_latch;
    logic          w_clr_index, w_clr_bits;

    assign w_rise       = r_sck_s2 & ~r_sck_prev;
    assign w_word       = {r_shift, r_mosi_s2};
    assign w_word_done  = w_rise && (r_bit_cnt == 5'd31);
    assign w_idle_hit   = !w_rise && (r_idle == IDLE_LAST);
    assign w_start_hunt = w_rise && !r_mosi_s2 && (r_zero_run >= 6'd31);
    assign dbg_state    = r_state;

    // Two-flop synchronizers for sck and mosi, plus previous sck for edge detect.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_sck_s1   <= 1'b0;
            r_sck_s2   <= 1'b0;
            r_sck_prev <= 1'b0;
            r_mosi_s1  <= 1'b0;
            r_mosi_s2  <= 1'b0;
        end else begin
            r_sck_s1   <= sck;
            r_sck_s2   <= r_sck_s1;
            r_sck_prev <= r_sck_s2;
            r_mosi_s1  <= mosi;
            r_mosi_s2  <= r_mosi_s1;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) r_state <= ST_HUNT;
        else       r_state <= w_state_next;
    end

    // Next state and per-cycle decode actions from the completed word.
    always_comb begin
        w_state_next = r_state;
        w_pix        = 1'b0;
        w_start      = 1'b0;
        w_end        = 1'b0;
        w_err        = 1'b0;
        w_latch      = 1'b0;
        w_clr_index  = 1'b0;
        w_clr_bits   = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (w_start_hunt) begin
                    w_start      = 1'b1;
                    w_clr_bits   = 1'b1;
                    w_clr_index  = 1'b1;
                    w_state_next = ST_PIXEL;
                end
            end
            ST_PIXEL: begin
                if (w_idle_hit) begin
                    w_err        = 1'b1;
                    w_latch      = 1'b1;
                    w_clr_bits   = 1'b1;
                    w_state_next = ST_HUNT;
                end else if (w_word_done) begin
                    if (w_word[31:29] == 3'b111) begin
                        // All-ones lands here too: a white pixel, not an end frame.
                        w_pix = 1'b1;
                        if (r_index == LAST_IDX) w_state_next = ST_END_WAIT;
                    end else if (w_word == 32'd0) begin
                        w_err       = 1'b1;
                        w_start     = 1'b1;
                        w_latch     = 1'b1;
                        w_clr_index = 1'b1;
                    end else begin
                        w_err        = 1'b1;
                        w_latch      = 1'b1;
                        w_state_next = ST_HUNT;
                    end
                end
            end
            ST_END_WAIT: begin
                if (w_idle_hit) begin
                    w_err        = 1'b1;
                    w_latch      = 1'b1;
                    w_clr_bits   = 1'b1;
                    w_state_next = ST_HUNT;
                end else if (w_word_done) begin
                    if (w_word == 32'hFFFF_FFFF) begin
                        w_end        = 1'b1;
                        w_latch      = 1'b1;
                        w_state_next = ST_HUNT;
                    end else if (w_word == 32'd0) begin
                        w_start      = 1'b1;
                        w_clr_index  = 1'b1;
                        w_state_next = ST_PIXEL;
                    end else begin
                        w_err        = 1'b1;
                        w_latch      = 1'b1;
                        w_state_next = ST_HUNT;
                    end
                end
            end
            default: w_state_next = ST_HUNT;
        endcase
    end

    // Shift register, bit counter, zero-run and idle counters.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_zero_run <= '0;
            r_idle     <= '0;
        end else begin
            if (w_rise) begin
                r_shift    <= w_word[30:0];
                r_bit_cnt  <= r_bit_cnt + 5'd1;
                r_idle     <= '0;
                if (r_mosi_s2)                r_zero_run <= '0;
                else if (r_zero_run != 6'd32) r_zero_run <= r_zero_run + 6'd1;
            end else if (r_idle != IDLE_MAX) begin
                r_idle <= r_idle + IW'(1);
            end
            if (w_clr_bits) r_bit_cnt <= '0;
        end
    end

    // Registered strobes, pixel fields, pixel index and latched pixel count.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_error <= 1'b0;
            pixel_index <= '0;
            brightness  <= '0;
            blue_out    <= '0;
            green_out   <= '0;
            red_out     <= '0;
            pixel_count <= '0;
            r_index     <= '0;
        end else begin
            pixel_valid <= w_pix;
            frame_start <= w_start;
            frame_end   <= w_end;
            frame_error <= w_err;
            if (w_pix) begin
                brightness  <= w_word[28:24];
                blue_out    <= w_word[23:16];
                green_out   <= w_word[15:8];
                red_out     <= w_word[7:0];
                pixel_index <= r_index;
                r_index     <= r_index + 8'd1;
            end
            if (w_latch)     pixel_count <= r_index;
            if (w_clr_index) r_index     <= '0;
        end
    end
endmodule
